// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Multicycle control sequencer (FETCH/DECODE/EXECUTE/MEM/WB) with
//               memory handshake stalls, illegal-opcode trap and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter int CNT_W        = 32,
    parameter int EN_ADDI      = 1,
    parameter int EN_BNE       = 1,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             ext_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             trap,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_illegal_next;
    logic             r_is_bne;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    // Branch flavour is captured in DECODE because opcode is ignored in BRANCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_is_bne  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (r_state == S_DECODE) begin
                r_is_bne <= (opcode == c_OP_BNE);
            end
        end
    end

    always_comb begin
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        i_or_d         = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_write_cond  = 1'b0;
        reg_dst        = 1'b0;
        reg_write      = 1'b0;
        mem_to_reg     = 1'b0;
        ext_op         = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        alu_op         = 2'b00;
        pc_source      = 2'b00;
        trap           = 1'b0;
        w_retire       = 1'b0;
        w_next         = r_state;
        w_illegal_next = S_FETCH;
        if (TRAP_ILLEGAL != 0) begin
            w_illegal_next = S_TRAP;
        end

        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                w_next    = w_illegal_next;
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEM_ADDR;
                    c_OP_RTYPE:       w_next = S_R_EXEC;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_BNE: begin
                        if (EN_BNE != 0) begin
                            w_next = S_BRANCH;
                        end
                    end
                    c_OP_ADDI: begin
                        if (EN_ADDI != 0) begin
                            w_next = S_ADDI_EXEC;
                        end
                    end
                    default: w_next = w_illegal_next;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                if (opcode == c_OP_LW) begin
                    w_next = S_MEM_RD;
                end else begin
                    w_next = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 2'b01;
                pc_write_cond = r_is_bne ? ~zero : zero;
                w_retire      = 1'b1;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_TRAP: begin
                trap   = 1'b1;
                w_next = S_TRAP;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Directed self-checking bench; instance 0 default, 1 EN_BNE=0,
//               2 TRAP_ILLEGAL=0, 3 CNT_W=4. Revision 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic        mem_req[4], mem_we[4], i_or_d[4], ir_write[4], pc_write[4];
    logic        pc_write_cond[4], reg_dst[4], reg_write[4], mem_to_reg[4];
    logic        ext_op[4], alu_src_a[4], trap[4];
    logic [1:0]  alu_src_b[4], alu_op[4], pc_source[4];
    logic [3:0]  st[4];
    logic [31:0] ret[4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CW = (g == 3) ? 4 : 32;
        logic [CW-1:0] w_ret;
        multicycle_control_fsm #(
            .CNT_W        (CW),
            .EN_ADDI      (1),
            .EN_BNE       ((g == 1) ? 0 : 1),
            .TRAP_ILLEGAL ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .opcode        (opcode),
            .zero          (zero),
            .mem_ready     (mem_ready),
            .mem_req       (mem_req[g]),
            .mem_we        (mem_we[g]),
            .i_or_d        (i_or_d[g]),
            .ir_write      (ir_write[g]),
            .pc_write      (pc_write[g]),
            .pc_write_cond (pc_write_cond[g]),
            .reg_dst       (reg_dst[g]),
            .reg_write     (reg_write[g]),
            .mem_to_reg    (mem_to_reg[g]),
            .ext_op        (ext_op[g]),
            .alu_src_a     (alu_src_a[g]),
            .alu_src_b     (alu_src_b[g]),
            .alu_op        (alu_op[g]),
            .pc_source     (pc_source[g]),
            .trap          (trap[g]),
            .state         (st[g]),
            .retired       (w_ret)
        );
        assign ret[g] = 32'(w_ret);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        mem_ready = 1'b0;
        zero      = 1'b0;
        reset     = 1'b1;
        #2;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++; if (st[0] !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st[0]); end
        checks++; if (mem_req[0] !== 1'b1 || pc_write[0] !== 1'b0 || alu_src_b[0] !== 2'b01)
            begin errors++; $display("FAIL reset_outputs: mem_req=%b pc_write=%b alu_src_b=%b expected 1 0 01", mem_req[0], pc_write[0], alu_src_b[0]); end
        checks++; if (ret[0] !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", ret[0]); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (st[0] !== 4'd0 || ir_write[0] !== 1'b0)
                begin errors++; $display("FAIL fetch_wait: state=%0d ir_write=%b expected 0 0", st[0], ir_write[0]); end
        end
        mem_ready = 1'b1;
        #1;
        checks++; if (ir_write[0] !== 1'b1 || pc_write[0] !== 1'b1)
            begin errors++; $display("FAIL fetch_ready: ir_write=%b pc_write=%b expected 1 1", ir_write[0], pc_write[0]); end
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (st[0] !== 4'd1 || ir_write[0] !== 1'b0 || pc_write[0] !== 1'b0)
            begin errors++; $display("FAIL fetch_to_decode: state=%0d ir_write=%b pc_write=%b expected 1 0 0", st[0], ir_write[0], pc_write[0]); end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        apply_reset();
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (st[0] !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, st[0], exp_st[i]); end
            if (i == 4) begin
                checks++; if (reg_write[0] !== 1'b1 || mem_to_reg[0] !== 1'b1 || reg_dst[0] !== 1'b0 || ret[0] !== 32'd0)
                    begin errors++; $display("FAIL lw_wb: reg_write=%b mem_to_reg=%b reg_dst=%b retired=%0d expected 1 1 0 0", reg_write[0], mem_to_reg[0], reg_dst[0], ret[0]); end
            end
            if (i < 5) step();
        end
        checks++; if (ret[0] !== 32'd1) begin errors++; $display("FAIL lw_retired: got %0d expected 1", ret[0]); end
    endtask

    task automatic test_sw();
        int we_cycles = 0;
        apply_reset();
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (mem_we[0] === 1'b1) we_cycles++;
            checks++; if (st[0] !== 4'd5 || reg_write[0] !== 1'b0 || mem_req[0] !== 1'b1 || i_or_d[0] !== 1'b1)
                begin errors++; $display("FAIL sw_wait[%0d]: state=%0d reg_write=%b mem_req=%b i_or_d=%b expected 5 0 1 1", i, st[0], reg_write[0], mem_req[0], i_or_d[0]); end
            step();
        end
        checks++; if (ret[0] !== 32'd0) begin errors++; $display("FAIL sw_early_retire: got %0d expected 0", ret[0]); end
        mem_ready = 1'b1;
        #1;
        if (mem_we[0] === 1'b1) we_cycles++;
        step();
        checks++; if (we_cycles !== 5) begin errors++; $display("FAIL sw_we_cycles: got %0d expected 5", we_cycles); end
        checks++; if (st[0] !== 4'd0 || ret[0] !== 32'd1)
            begin errors++; $display("FAIL sw_done: state=%0d retired=%0d expected 0 1", st[0], ret[0]); end
    endtask

    task automatic test_branch();
        apply_reset();
        opcode    = 6'b000100;
        zero      = 1'b1;
        mem_ready = 1'b1;
        step();
        step();
        checks++; if (st[0] !== 4'd8 || pc_write_cond[0] !== 1'b1 || pc_source[0] !== 2'b01 || alu_op[0] !== 2'b01)
            begin errors++; $display("FAIL beq_taken: state=%0d pwc=%b pc_source=%b alu_op=%b expected 8 1 01 01", st[0], pc_write_cond[0], pc_source[0], alu_op[0]); end
        zero = 1'b0;
        #1;
        checks++; if (pc_write_cond[0] !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got %b expected 0", pc_write_cond[0]); end
        step();
        opcode = 6'b000101;
        zero   = 1'b1;
        step();
        step();
        checks++; if (st[0] !== 4'd8 || pc_write_cond[0] !== 1'b0)
            begin errors++; $display("FAIL bne_zero1: state=%0d pwc=%b expected 8 0", st[0], pc_write_cond[0]); end
        zero = 1'b0;
        #1;
        checks++; if (pc_write_cond[0] !== 1'b1) begin errors++; $display("FAIL bne_zero0: got %b expected 1", pc_write_cond[0]); end
        checks++; if (st[1] !== 4'd12 || trap[1] !== 1'b1)
            begin errors++; $display("FAIL bne_disabled_trap: state=%0d trap=%b expected 12 1", st[1], trap[1]); end
        step();
        checks++; if (ret[0] !== 32'd2) begin errors++; $display("FAIL branch_retired: got %0d expected 2", ret[0]); end
    endtask

    task automatic test_addi_jump();
        apply_reset();
        opcode    = 6'b001000;
        mem_ready = 1'b1;
        step();
        step();
        checks++; if (st[0] !== 4'd10 || alu_src_b[0] !== 2'b10 || alu_src_a[0] !== 1'b1 || ext_op[0] !== 1'b1)
            begin errors++; $display("FAIL addi_exec: state=%0d alu_src_b=%b alu_src_a=%b ext_op=%b expected 10 10 1 1", st[0], alu_src_b[0], alu_src_a[0], ext_op[0]); end
        step();
        checks++; if (st[0] !== 4'd11 || reg_write[0] !== 1'b1 || reg_dst[0] !== 1'b0)
            begin errors++; $display("FAIL addi_wb: state=%0d reg_write=%b reg_dst=%b expected 11 1 0", st[0], reg_write[0], reg_dst[0]); end
        step();
        opcode = 6'b000010;
        step();
        step();
        checks++; if (st[0] !== 4'd9 || pc_write[0] !== 1'b1 || pc_source[0] !== 2'b10)
            begin errors++; $display("FAIL jump: state=%0d pc_write=%b pc_source=%b expected 9 1 10", st[0], pc_write[0], pc_source[0]); end
        step();
        checks++; if (ret[0] !== 32'd2) begin errors++; $display("FAIL addi_jump_retired: got %0d expected 2", ret[0]); end
    endtask

    task automatic test_illegal();
        logic held = 1'b1;
        apply_reset();
        opcode    = 6'b111111;
        mem_ready = 1'b1;
        step();
        step();
        checks++; if (st[0] !== 4'd12 || trap[0] !== 1'b1)
            begin errors++; $display("FAIL illegal_trap: state=%0d trap=%b expected 12 1", st[0], trap[0]); end
        checks++; if (st[2] !== 4'd0 || trap[2] !== 1'b0 || ret[2] !== 32'd0)
            begin errors++; $display("FAIL illegal_nop: state=%0d trap=%b retired=%0d expected 0 0 0", st[2], trap[2], ret[2]); end
        opcode = 6'b100011;
        for (int i = 0; i < 20; i++) begin
            step();
            if (st[0] !== 4'd12 || trap[0] !== 1'b1 || mem_req[0] !== 1'b0 || reg_write[0] !== 1'b0 || pc_write[0] !== 1'b0) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL trap_held: state=%0d trap=%b mem_req=%b expected 12 1 0", st[0], trap[0], mem_req[0]); end
        checks++; if (ret[0] !== 32'd0) begin errors++; $display("FAIL trap_retired: got %0d expected 0", ret[0]); end
    endtask

    task automatic test_rtype_wrap();
        apply_reset();
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            step();
            step();
            if (n == 0) begin
                checks++; if (st[0] !== 4'd6 || alu_op[0] !== 2'b10 || alu_src_a[0] !== 1'b1)
                    begin errors++; $display("FAIL r_exec: state=%0d alu_op=%b alu_src_a=%b expected 6 10 1", st[0], alu_op[0], alu_src_a[0]); end
            end
            step();
            if (n == 0) begin
                checks++; if (st[0] !== 4'd7 || reg_write[0] !== 1'b1 || reg_dst[0] !== 1'b1)
                    begin errors++; $display("FAIL r_wb: state=%0d reg_write=%b reg_dst=%b expected 7 1 1", st[0], reg_write[0], reg_dst[0]); end
            end
            step();
            if (n == 14) begin
                checks++; if (ret[3] !== 32'd15) begin errors++; $display("FAIL cnt4_at15: got %0d expected 15", ret[3]); end
            end
        end
        checks++; if (ret[3] !== 32'd0) begin errors++; $display("FAIL cnt4_wrap: got %0d expected 0", ret[3]); end
        checks++; if (ret[0] !== 32'd16) begin errors++; $display("FAIL cnt32_16: got %0d expected 16", ret[0]); end
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        opcode    = 6'b000010;
        mem_ready = 1'b1;
        step();
        step();
        step();
        opcode = 6'b100011;
        step();
        step();
        step();
        mem_ready = 1'b0;
        step();
        checks++; if (st[0] !== 4'd3 || mem_req[0] !== 1'b1 || i_or_d[0] !== 1'b1 || ret[0] !== 32'd1)
            begin errors++; $display("FAIL mem_rd_stall: state=%0d mem_req=%b i_or_d=%b retired=%0d expected 3 1 1 1", st[0], mem_req[0], i_or_d[0], ret[0]); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (st[0] !== 4'd0 || ret[0] !== 32'd0 || i_or_d[0] !== 1'b0 || mem_req[0] !== 1'b1)
            begin errors++; $display("FAIL async_reset_mid: state=%0d retired=%0d i_or_d=%b mem_req=%b expected 0 0 0 1", st[0], ret[0], i_or_d[0], mem_req[0]); end
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #1;
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_addi_jump();
        test_illegal();
        test_rtype_wrap();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
